// File: rtl/lc3_control_fsm_if.sv
// Control bundle between the LC-3 sequencer and its datapath: IR/flags/memory-ready in, controls out.
// Latency: pure wiring, no storage.
// Backpressure: mem_ready stalls the sequencer in its memory states; nothing else pushes back.
interface lc3_control_fsm_if #(
   parameter int IR_W  = 16,
   parameter int REG_W = 3
);
   logic [IR_W-1:0]  IR;
   logic             N;
   logic             Z;
   logic             P;
   logic             mem_ready;
   logic [1:0]       aluControl;
   logic             enaALU;
   logic             enaMARM;
   logic             enaMDR;
   logic             enaPC;
   logic             selMAR;
   logic             selEAB1;
   logic [1:0]       selEAB2;
   logic [1:0]       selPC;
   logic             selMDR;
   logic             selALUB;
   logic             ldPC;
   logic             ldIR;
   logic             ldMAR;
   logic             ldMDR;
   logic [REG_W-1:0] SR1;
   logic [REG_W-1:0] SR2;
   logic [REG_W-1:0] DR;
   logic             regWE;
   logic             memWE;
   logic             halt;
   logic [5:0]       state;

   // Sequencer side.
   modport master (
      input  IR, N, Z, P, mem_ready,
      output aluControl, enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1, selEAB2,
             selPC, selMDR, selALUB, ldPC, ldIR, ldMAR, ldMDR, SR1, SR2, DR,
             regWE, memWE, halt, state
   );

   // Datapath side.
   modport slave (
      output IR, N, Z, P, mem_ready,
      input  aluControl, enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1, selEAB2,
             selPC, selMDR, selALUB, ldPC, ldIR, ldMAR, ldMDR, SR1, SR2, DR,
             regWE, memWE, halt, state
   );
endinterface

// File: rtl/lc3_control_fsm.sv
// LC-3 Moore control unit sequencing fetch/decode/execute for ADD/AND/NOT/BR/LD/ST/LEA/JMP.
// Latency: 5 cycles ALU/LEA/JMP/BR-not-taken, 6 BR taken, 7 LD/ST from FETCH1 with ready memory.
// Backpressure: states 33/25/16 hold while mem_ready is low (when MEM_WAIT=1); all others advance.
module lc3_control_fsm #(
   parameter int IR_W            = 16,
   parameter int NUM_REGS        = 8,
   parameter bit MEM_WAIT        = 1'b1,
   parameter bit ENABLE_IMM      = 1'b1,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input logic             clk,
   input logic             reset,
   lc3_control_fsm_if.master bus
);
   localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   // Encodings match the classic LC-3 microsequencer state numbers so debug dumps line up.
   typedef enum logic [5:0] {
      S_BR       = 6'd0,
      S_ADD      = 6'd1,
      S_LD       = 6'd2,
      S_ST       = 6'd3,
      S_AND      = 6'd5,
      S_NOT      = 6'd9,
      S_JMP      = 6'd12,
      S_LEA      = 6'd14,
      S_ST_MEM   = 6'd16,
      S_FETCH1   = 6'd18,
      S_BR_TAKEN = 6'd22,
      S_ST_DATA  = 6'd23,
      S_LD_MEM   = 6'd25,
      S_LD_WB    = 6'd27,
      S_DECODE   = 6'd32,
      S_FETCH2   = 6'd33,
      S_FETCH3   = 6'd35,
      S_START    = 6'd62,
      S_HALT     = 6'd63
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [3:0]       opcode;
   logic [REG_W-1:0] f_dr;
   logic [REG_W-1:0] f_sr1;
   logic [REG_W-1:0] f_sr2;
   logic             mem_ok;
   logic             br_taken;
   logic             unused_ir;

   assign opcode    = bus.IR[IR_W-1 -: 4];
   assign f_dr      = REG_W'(bus.IR[11:9]);
   assign f_sr1     = REG_W'(bus.IR[8:6]);
   assign f_sr2     = REG_W'(bus.IR[2:0]);
   // Single-cycle memory builds simply never wait on the handshake.
   assign mem_ok    = !MEM_WAIT || bus.mem_ready;
   assign br_taken  = (bus.IR[11] & bus.N) | (bus.IR[10] & bus.Z) | (bus.IR[9] & bus.P);
   assign unused_ir = ^bus.IR;
   assign bus.state = state_q;

   // State register; reset drops straight to START so an in-flight write is cut off.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_START;
      else        state_q <= state_d;
   end

   // Next-state and Moore outputs; everything defaults low so unlisted controls stay idle.
   always_comb begin
      state_d        = state_q;
      bus.aluControl = 2'b00;
      bus.enaALU     = 1'b0;
      bus.enaMARM    = 1'b0;
      bus.enaMDR     = 1'b0;
      bus.enaPC      = 1'b0;
      bus.selMAR     = 1'b0;
      bus.selEAB1    = 1'b0;
      bus.selEAB2    = 2'b00;
      bus.selPC      = 2'b00;
      bus.selMDR     = 1'b0;
      bus.selALUB    = 1'b0;
      bus.ldPC       = 1'b0;
      bus.ldIR       = 1'b0;
      bus.ldMAR      = 1'b0;
      bus.ldMDR      = 1'b0;
      bus.SR1        = '0;
      bus.SR2        = '0;
      bus.DR         = '0;
      bus.regWE      = 1'b0;
      bus.memWE      = 1'b0;
      bus.halt       = 1'b0;
      case (state_q)
         S_START:  state_d = S_FETCH1;
         S_FETCH1: begin
            bus.enaPC = 1'b1;
            bus.ldMAR = 1'b1;
            bus.ldPC  = 1'b1;
            state_d   = S_FETCH2;
         end
         S_FETCH2: begin
            bus.selMDR = 1'b1;
            bus.ldMDR  = 1'b1;
            if (mem_ok) state_d = S_FETCH3;
         end
         S_FETCH3: begin
            bus.enaMDR = 1'b1;
            bus.ldIR   = 1'b1;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               4'b0001: state_d = S_ADD;
               4'b0101: state_d = S_AND;
               4'b1001: state_d = S_NOT;
               4'b0000: state_d = S_BR;
               4'b0010: state_d = S_LD;
               4'b0011: state_d = S_ST;
               4'b1110: state_d = S_LEA;
               4'b1100: state_d = S_JMP;
               default: state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH1;
            endcase
         end
         S_ADD, S_AND, S_NOT: begin
            bus.DR         = f_dr;
            bus.SR1        = f_sr1;
            bus.SR2        = f_sr2;
            bus.enaALU     = 1'b1;
            bus.regWE      = 1'b1;
            bus.aluControl = (state_q == S_ADD) ? 2'b01 : (state_q == S_AND) ? 2'b10 : 2'b11;
            bus.selALUB    = (state_q != S_NOT) && ENABLE_IMM && bus.IR[5];
            state_d        = S_FETCH1;
         end
         S_BR:     state_d = br_taken ? S_BR_TAKEN : S_FETCH1;
         S_BR_TAKEN: begin
            bus.selEAB2 = 2'b10;
            bus.selPC   = 2'b10;
            bus.ldPC    = 1'b1;
            state_d     = S_FETCH1;
         end
         S_LD, S_ST: begin
            bus.selEAB2 = 2'b10;
            bus.selMAR  = 1'b1;
            bus.enaMARM = 1'b1;
            bus.ldMAR   = 1'b1;
            state_d     = (state_q == S_LD) ? S_LD_MEM : S_ST_DATA;
         end
         S_LD_MEM: begin
            bus.selMDR = 1'b1;
            bus.ldMDR  = 1'b1;
            if (mem_ok) state_d = S_LD_WB;
         end
         S_LD_WB: begin
            bus.enaMDR = 1'b1;
            bus.DR     = f_dr;
            bus.regWE  = 1'b1;
            state_d    = S_FETCH1;
         end
         S_ST_DATA: begin
            // Store data comes from the SR field at IR[11:9], passed through the ALU.
            bus.SR1    = f_dr;
            bus.enaALU = 1'b1;
            bus.ldMDR  = 1'b1;
            state_d    = S_ST_MEM;
         end
         S_ST_MEM: begin
            bus.memWE = 1'b1;
            if (mem_ok) state_d = S_FETCH1;
         end
         S_LEA: begin
            bus.selEAB2 = 2'b10;
            bus.selMAR  = 1'b1;
            bus.enaMARM = 1'b1;
            bus.DR      = f_dr;
            bus.regWE   = 1'b1;
            state_d     = S_FETCH1;
         end
         S_JMP: begin
            bus.SR1    = f_sr1;
            bus.enaALU = 1'b1;
            bus.selPC  = 2'b01;
            bus.ldPC   = 1'b1;
            state_d    = S_FETCH1;
         end
         S_HALT:   bus.halt = 1'b1;
         default:  state_d = S_START;
      endcase
   end
endmodule
